// File: rtl/hilo_issue_ctrl.sv
// Issue arbitration and HI/LO architectural state for the shared non-pipelined HILO unit.
// Grants one slot per accept window, bypasses HI/LO into the FU and drains it on flush.
module hilo_issue_ctrl #(
    parameter int unsigned TAG_W = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [7:0]        req0_op,
    input  logic [31:0]       req0_src,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req0_rfwe,
    input  logic              req1_valid,
    input  logic [7:0]        req1_op,
    input  logic [31:0]       req1_src,
    input  logic [TAG_W-1:0]  req1_tag,
    input  logic              req1_rfwe,
    output logic              grant0,
    output logic              grant1,
    output logic              fu_ready,
    output logic [7:0]        fu_op,
    output logic [31:0]       fu_rdata1,
    output logic [63:0]       fu_rdata2,
    input  logic              fu_busy,
    input  logic              fu_done,
    input  logic [31:0]       fu_wdata,
    input  logic [31:0]       fu_extra_wdata,
    output logic              cb_valid,
    output logic [TAG_W-1:0]  cb_tag,
    output logic              rf_we,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       hi_q,
    output logic [31:0]       lo_q
);
    localparam int unsigned OP_W    = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_MTHI = 5;
    localparam int unsigned OP_MTLO = 4;
    // mult/multu/div/divu all write both HI and LO
    localparam logic [OP_W-1:0] ARITH_MASK = 8'h0F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic                done_ok;
    logic [OP_W-1:0]     op_q;
    logic [TAG_W-1:0]    tag_q;
    logic                rfwe_q;
    logic                hi_we;
    logic                lo_we;
    logic [DATA_W-1:0]   hi_d;
    logic [DATA_W-1:0]   lo_d;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept window, arbitration and completion qualification
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done_ok = 1'b0;
        case (state_q)
            IDLE: begin
                accept = ~flush;
            end
            EXEC: begin
                if (fu_done) begin
                    state_d = IDLE;
                    if (!flush) begin
                        done_ok = 1'b1;
                        accept  = 1'b1;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fu_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!resetn) begin
            accept  = 1'b0;
            done_ok = 1'b0;
        end
        grant0 = accept & req0_valid;
        grant1 = accept & ~req0_valid & req1_valid;
        if (grant0 | grant1) begin
            state_d = EXEC;
        end
    end

    // FU start mux, HI/LO write decode and bypass, commit-buffer completion
    always_comb begin
        fu_ready  = grant0 | grant1;
        fu_op     = '0;
        fu_rdata1 = '0;
        if (grant0) begin
            fu_op     = req0_op;
            fu_rdata1 = req0_src;
        end else if (grant1) begin
            fu_op     = req1_op;
            fu_rdata1 = req1_src;
        end

        hi_we = done_ok & (op_q[OP_MTHI] | (|(op_q & ARITH_MASK)));
        lo_we = done_ok & (op_q[OP_MTLO] | (|(op_q & ARITH_MASK)));
        hi_d  = hi_we ? fu_extra_wdata : hi_q;
        lo_d  = lo_we ? fu_wdata       : lo_q;
        fu_rdata2 = {hi_d, lo_d};

        cb_valid = done_ok;
        cb_tag   = done_ok ? tag_q : '0;
        rf_we    = done_ok & rfwe_q;
        rf_wdata = done_ok ? fu_wdata : '0;
    end

    // In-flight op tracking
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q   <= '0;
            tag_q  <= '0;
            rfwe_q <= 1'b0;
        end else if (grant0) begin
            op_q   <= req0_op;
            tag_q  <= req0_tag;
            rfwe_q <= req0_rfwe;
        end else if (grant1) begin
            op_q   <= req1_op;
            tag_q  <= req1_tag;
            rfwe_q <= req1_rfwe;
        end
    end

    // Architectural HI/LO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // The FU never signals completion while still stalling
    assert property (@(posedge clk) disable iff (!resetn) !(fu_done && fu_busy));

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// Scoreboard bench for hilo_issue_ctrl with a behavioural HILO FU model.
module tb_hilo_issue_ctrl;
    localparam int unsigned TAG_W = 6;
    localparam logic [7:0] OP_MFHI  = 8'h80;
    localparam logic [7:0] OP_MFLO  = 8'h40;
    localparam logic [7:0] OP_MTHI  = 8'h20;
    localparam logic [7:0] OP_MTLO  = 8'h10;
    localparam logic [7:0] OP_MULT  = 8'h08;
    localparam logic [7:0] OP_MULTU = 8'h04;
    localparam logic [7:0] OP_DIV   = 8'h02;
    localparam logic [7:0] OP_DIVU  = 8'h01;
    localparam int DIV_LAT = 34;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              flush = 1'b0;
    logic              req0_valid = 1'b0;
    logic [7:0]        req0_op = '0;
    logic [31:0]       req0_src = '0;
    logic [TAG_W-1:0]  req0_tag = '0;
    logic              req0_rfwe = 1'b0;
    logic              req1_valid = 1'b0;
    logic [7:0]        req1_op = '0;
    logic [31:0]       req1_src = '0;
    logic [TAG_W-1:0]  req1_tag = '0;
    logic              req1_rfwe = 1'b0;
    logic              grant0, grant1, fu_ready;
    logic [7:0]        fu_op;
    logic [31:0]       fu_rdata1;
    logic [63:0]       fu_rdata2;
    logic              fu_busy = 1'b0;
    logic              fu_done = 1'b0;
    logic [31:0]       fu_wdata = '0;
    logic [31:0]       fu_extra_wdata = '0;
    logic              cb_valid, rf_we;
    logic [TAG_W-1:0]  cb_tag;
    logic [31:0]       rf_wdata, hi_q, lo_q;

    logic [31:0]       fu_rt = '0;   // rt operand seen by the FU model
    int                n_cmp = 0;
    int                n_fail = 0;
    logic [31:0]       ref_hi = '0;
    logic [31:0]       ref_lo = '0;

    typedef struct {
        logic [7:0]       op;
        logic [31:0]      src;
        logic [31:0]      rt;
        logic [TAG_W-1:0] tag;
        logic             rfwe;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hilo_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_src(req0_src),
        .req0_tag(req0_tag), .req0_rfwe(req0_rfwe),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_src(req1_src),
        .req1_tag(req1_tag), .req1_rfwe(req1_rfwe),
        .grant0(grant0), .grant1(grant1), .fu_ready(fu_ready), .fu_op(fu_op),
        .fu_rdata1(fu_rdata1), .fu_rdata2(fu_rdata2), .fu_busy(fu_busy),
        .fu_done(fu_done), .fu_wdata(fu_wdata), .fu_extra_wdata(fu_extra_wdata),
        .cb_valid(cb_valid), .cb_tag(cb_tag), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .hi_q(hi_q), .lo_q(lo_q)
    );

    // FU result as {extra_wdata(HI), wdata(LO)}
    function automatic logic [63:0] calc(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
        logic [63:0] r;
        r = '0;
        case (op)
            OP_MFHI:  r = {32'h0, hl[63:32]};
            OP_MFLO:  r = {32'h0, hl[31:0]};
            OP_MTHI:  r = {a, ~a};
            OP_MTLO:  r = {~a, a};
            OP_MULT:  r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            OP_MULTU: r = {32'h0, a} * {32'h0, b};
            OP_DIV:   if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            OP_DIVU:  if (b != 0) r = {a % b, a / b};
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [7:0] op);
        if (op == OP_MULT || op == OP_MULTU) return 2;
        if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
        return 1;
    endfunction

    // Behavioural HILO FU: samples the start pulse at the edge, completes after its latency
    int          fu_cnt = 0;
    logic [63:0] fu_res = '0;
    always @(posedge clk) begin : fu_model
        logic        g, r;
        logic [7:0]  o;
        logic [31:0] a, b;
        logic [63:0] hl;
        g = fu_ready; r = resetn; o = fu_op; a = fu_rdata1; b = fu_rt; hl = fu_rdata2;
        #1;
        if (!r) begin
            fu_cnt = 0;
        end else if (g) begin
            fu_res = calc(o, a, b, hl);
            fu_cnt = latency(o);
        end else if (fu_cnt > 0) begin
            fu_cnt = fu_cnt - 1;
        end
        fu_done        = (fu_cnt == 1);
        fu_busy        = (fu_cnt > 1);
        fu_wdata       = fu_res[31:0];
        fu_extra_wdata = fu_res[63:32];
    end

    // Scoreboard: completions popped in order, HI/LO reference tracked every cycle
    always @(negedge clk) begin : scoreboard
        exp_t        e;
        logic [63:0] r;
        if (!resetn) begin
            exp_q.delete();
            ref_hi = '0;
            ref_lo = '0;
        end else begin
            n_cmp++;
            if ({hi_q, lo_q} !== {ref_hi, ref_lo}) begin
                n_fail++;
                $display("FAIL hilo_state: got %h_%h want %h_%h", hi_q, lo_q, ref_hi, ref_lo);
            end
            if (cb_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cb_unexpected: got cb_valid=1 tag=%0d want no completion", cb_tag);
                end else begin
                    e = exp_q.pop_front();
                    r = calc(e.op, e.src, e.rt, {ref_hi, ref_lo});
                    if (cb_tag !== e.tag || rf_we !== e.rfwe) begin
                        n_fail++;
                        $display("FAIL cb_fields: got tag=%0d rf_we=%b want tag=%0d rf_we=%b",
                                 cb_tag, rf_we, e.tag, e.rfwe);
                    end
                    if (e.rfwe) begin
                        n_cmp++;
                        if (rf_wdata !== r[31:0]) begin
                            n_fail++;
                            $display("FAIL rf_wdata: got %h want %h (tag %0d)", rf_wdata, r[31:0], e.tag);
                        end
                    end
                    if (e.op == OP_MTHI || (e.op & 8'h0F) != 8'h00) ref_hi = r[63:32];
                    if (e.op == OP_MTLO || (e.op & 8'h0F) != 8'h00) ref_lo = r[31:0];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input int slot, input logic [7:0] op, input logic [31:0] src,
                         input logic [TAG_W-1:0] tag, input logic rfwe);
        if (slot == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_src = src; req0_tag = tag; req0_rfwe = rfwe;
            req1_valid = 1'b0;
        end else begin
            req0_valid = 1'b0;
            req1_valid = 1'b1; req1_op = op; req1_src = src; req1_tag = tag; req1_rfwe = rfwe;
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [31:0] src,
                        input logic [TAG_W-1:0] tag, input logic rfwe);
        exp_t e;
        e.op = op; e.src = src; e.rt = fu_rt; e.tag = tag; e.rfwe = rfwe;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(0, OP_MULT, 32'h1, 6'd9, 1'b0);
        tick(); tick();
        sample();
        n_cmp++;
        if ({grant0, grant1, fu_ready, fu_op, fu_rdata1, fu_rdata2, cb_valid, cb_tag,
             rf_we, rf_wdata, hi_q, lo_q} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant0=%b cb_valid=%b hi=%h lo=%h want all 0",
                     grant0, cb_valid, hi_q, lo_q);
        end
        tick();
        resetn = 1'b1;
        req0_valid = 1'b0;
    endtask

    task automatic test_mthi();
        tick();
        fu_rt = '0;
        drive(0, OP_MTHI, 32'h12345678, 6'd1, 1'b0);
        push(OP_MTHI, 32'h12345678, 6'd1, 1'b0);
        sample();
        n_cmp++;
        if ({grant0, grant1, fu_ready, fu_op, fu_rdata1} !== {1'b1, 1'b0, 1'b1, OP_MTHI, 32'h12345678}) begin
            n_fail++;
            $display("FAIL mthi_grant: got g0=%b g1=%b rdy=%b op=%h src=%h want 1 0 1 %h 12345678",
                     grant0, grant1, fu_ready, fu_op, fu_rdata1, OP_MTHI);
        end
        tick();
        req0_valid = 1'b0;
        sample();
        n_cmp++;
        if ({cb_valid, rf_we, cb_tag} !== {1'b1, 1'b0, 6'd1}) begin
            n_fail++;
            $display("FAIL mthi_complete: got cb_valid=%b rf_we=%b tag=%0d want 1 0 1", cb_valid, rf_we, cb_tag);
        end
        tick();
        sample();
        n_cmp++;
        if (hi_q !== 32'h12345678) begin
            n_fail++;
            $display("FAIL mthi_hi: got %h want 12345678", hi_q);
        end
    endtask

    task automatic test_both_slots();
        tick();
        fu_rt = 32'd2;
        req0_valid = 1'b1; req0_op = OP_MULT; req0_src = 32'hFFFFFFFF; req0_tag = 6'd2; req0_rfwe = 1'b0;
        req1_valid = 1'b1; req1_op = OP_MFLO; req1_src = 32'h0;        req1_tag = 6'd3; req1_rfwe = 1'b1;
        push(OP_MULT, 32'hFFFFFFFF, 6'd2, 1'b0);
        sample();
        n_cmp++;
        if ({grant0, grant1} !== 2'b10) begin
            n_fail++;
            $display("FAIL both_arb: got g0=%b g1=%b want 1 0", grant0, grant1);
        end
        tick();
        req0_valid = 1'b0;
        sample();
        n_cmp++;
        if ({grant1, cb_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL both_wait: got g1=%b cb_valid=%b want 0 0", grant1, cb_valid);
        end
        tick();
        push(OP_MFLO, 32'h0, 6'd3, 1'b1);
        sample();
        n_cmp++;
        if ({grant1, fu_op, fu_rdata2} !== {1'b1, OP_MFLO, 64'hFFFFFFFF_FFFFFFFE}) begin
            n_fail++;
            $display("FAIL both_bypass: got g1=%b op=%h rdata2=%h want 1 %h FFFFFFFFFFFFFFFE",
                     grant1, fu_op, fu_rdata2, OP_MFLO);
        end
        tick();
        req1_valid = 1'b0;
        sample();
        n_cmp++;
        if ({rf_we, rf_wdata, lo_q} !== {1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE}) begin
            n_fail++;
            $display("FAIL both_mflo: got rf_we=%b rf_wdata=%h lo=%h want 1 FFFFFFFE FFFFFFFE",
                     rf_we, rf_wdata, lo_q);
        end
    endtask

    task automatic test_divu();
        tick();
        fu_rt = 32'd7;
        drive(0, OP_DIVU, 32'd100, 6'd4, 1'b0);
        push(OP_DIVU, 32'd100, 6'd4, 1'b0);
        sample();
        n_cmp++;
        if (grant0 !== 1'b1) begin
            n_fail++;
            $display("FAIL divu_grant: got %b want 1", grant0);
        end
        for (int i = 1; i <= DIV_LAT; i++) begin
            tick();
            if (i == 1) drive(0, OP_MFHI, 32'h0, 6'd5, 1'b1);
            if (i == DIV_LAT) push(OP_MFHI, 32'h0, 6'd5, 1'b1);
            sample();
            n_cmp++;
            if (i < DIV_LAT) begin
                if ({grant0, grant1, cb_valid} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL divu_busy: cycle %0d got g0=%b g1=%b cb_valid=%b want 0 0 0",
                             i, grant0, grant1, cb_valid);
                end
            end else if ({cb_valid, grant0} !== 2'b11) begin
                n_fail++;
                $display("FAIL divu_done: got cb_valid=%b g0=%b want 1 1", cb_valid, grant0);
            end
        end
        tick();
        req0_valid = 1'b0;
        sample();
        n_cmp++;
        if ({hi_q, lo_q, rf_wdata} !== {32'd2, 32'd14, 32'd2}) begin
            n_fail++;
            $display("FAIL divu_result: got hi=%0d lo=%0d mfhi=%0d want 2 14 2", hi_q, lo_q, rf_wdata);
        end
    endtask

    task automatic test_flush_div();
        tick();
        fu_rt = 32'd3;
        drive(0, OP_DIV, 32'd50, 6'd6, 1'b0);
        sample();
        n_cmp++;
        if (grant0 !== 1'b1) begin
            n_fail++;
            $display("FAIL fdiv_grant: got %b want 1", grant0);
        end
        for (int i = 1; i <= DIV_LAT + 1; i++) begin
            tick();
            if (i == 1) drive(0, OP_MTLO, 32'h0000AAAA, 6'd7, 1'b0);
            flush = (i == 5 || i == 10);
            if (i == DIV_LAT + 1) push(OP_MTLO, 32'h0000AAAA, 6'd7, 1'b0);
            sample();
            n_cmp++;
            if (i <= DIV_LAT) begin
                if ({grant0, cb_valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL fdiv_drain: cycle %0d got g0=%b cb_valid=%b want 0 0", i, grant0, cb_valid);
                end
            end else if (grant0 !== 1'b1) begin
                n_fail++;
                $display("FAIL fdiv_regrant: got g0=%b want 1", grant0);
            end
        end
        tick();
        req0_valid = 1'b0;
        tick();
        sample();
        n_cmp++;
        if ({hi_q, lo_q} !== {32'd2, 32'h0000AAAA}) begin
            n_fail++;
            $display("FAIL fdiv_hilo: got hi=%h lo=%h want 00000002 0000AAAA", hi_q, lo_q);
        end
    endtask

    task automatic test_flush_done();
        tick();
        drive(0, OP_MTLO, 32'h00000055, 6'd8, 1'b0);
        sample();
        n_cmp++;
        if (grant0 !== 1'b1) begin
            n_fail++;
            $display("FAIL fdone_grant: got %b want 1", grant0);
        end
        tick();
        flush = 1'b1;
        drive(0, OP_MFLO, 32'h0, 6'd9, 1'b1);
        sample();
        n_cmp++;
        if ({cb_valid, grant0} !== 2'b00) begin
            n_fail++;
            $display("FAIL fdone_discard: got cb_valid=%b g0=%b want 0 0", cb_valid, grant0);
        end
        tick();
        flush = 1'b0;
        push(OP_MFLO, 32'h0, 6'd9, 1'b1);
        sample();
        n_cmp++;
        if ({grant0, lo_q} !== {1'b1, 32'h0000AAAA}) begin
            n_fail++;
            $display("FAIL fdone_idle: got g0=%b lo=%h want 1 0000AAAA", grant0, lo_q);
        end
        tick();
        req0_valid = 1'b0;
        sample();
    endtask

    task automatic test_back_to_back();
        int          slots[6] = '{0, 1, 0, 1, 0, 0};
        logic [7:0]  ops[6]   = '{OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, OP_MULTU, OP_MFHI};
        logic [31:0] srcs[6]  = '{32'hCAFE0001, 32'h0BADF00D, 32'h0, 32'h0, 32'h00010000, 32'h0};
        logic        rfwes[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          wait_n;
        tick();
        fu_rt = 32'h00030000;
        for (int k = 0; k < 6; k++) begin
            wait_n = (k == 0) ? 1 : latency(ops[k-1]);
            drive(slots[k], ops[k], srcs[k], TAG_W'(10 + k), rfwes[k]);
            push(ops[k], srcs[k], TAG_W'(10 + k), rfwes[k]);
            for (int c = 1; c <= wait_n; c++) begin
                sample();
                n_cmp++;
                if (c < wait_n) begin
                    if ({grant0, grant1} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL b2b_hold: op %0d got g0=%b g1=%b want 0 0", k, grant0, grant1);
                    end
                end else if ({grant0, grant1} !== ((slots[k] == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL b2b_grant: op %0d got g0=%b g1=%b want slot %0d", k, grant0, grant1, slots[k]);
                end
                tick();
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sample();
        tick();
        sample();
        n_cmp++;
        if ({hi_q, lo_q} !== {32'd3, 32'd0}) begin
            n_fail++;
            $display("FAIL b2b_hilo: got hi=%h lo=%h want 00000003 00000000", hi_q, lo_q);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        fu_rt = 32'd3;
        drive(0, OP_MULT, 32'd7, 6'd20, 1'b0);
        sample();
        n_cmp++;
        if (grant0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_grant: got %b want 1", grant0);
        end
        tick();
        resetn = 1'b0;
        drive(0, OP_MFHI, 32'h0, 6'd21, 1'b1);
        sample();
        n_cmp++;
        if (grant0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_gate: got g0=%b want 0", grant0);
        end
        tick();
        sample();
        n_cmp++;
        if ({grant0, grant1, fu_ready, fu_op, fu_rdata1, fu_rdata2, cb_valid, cb_tag,
             rf_we, rf_wdata, hi_q, lo_q} !== '0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got g0=%b cb_valid=%b hi=%h lo=%h want all 0",
                     grant0, cb_valid, hi_q, lo_q);
        end
        tick();
        resetn = 1'b1;
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_cmp++;
            if (cb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_abandon: got cb_valid=%b want 0", cb_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_mthi();
        test_both_slots();
        test_divu();
        test_flush_div();
        test_flush_done();
        test_back_to_back();
        test_reset_mid();
        sample();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d pending completions want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test want finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hilo_issue_ctrl.md
# hilo_issue_ctrl

Issue controller and HI/LO architectural state holder for the single non-pipelined HILO functional unit (mul/div/mfhi/mflo/mthi/mtlo). Sits between the two issue slots and the HILO FU. Arbitrates which slot may start the FU, feeds it the current HI:LO pair with same-cycle bypass, and tracks the in-flight operation. Applies HI/LO updates and forwards register-file results to the commit buffer, and drains the un-annullable FU on pipeline flush.

## Interface
- TAG_W, 6, width of commit-buffer tag carried with each op
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush; cancels all pending and in-flight work
- req0_valid / req1_valid  in  1  issue slot request; slot 0 is older in program order
- req0_op / req1_op  in  8  one-hot {mfhi,mflo,mthi,mtlo,mult,multu,div,divu}
- req0_src / req1_src  in  32  rs operand
- req0_tag / req1_tag  in  TAG_W  commit-buffer tag
- req0_rfwe / req1_rfwe  in  1  op writes GPR (mfhi/mflo)
- grant0 / grant1  out  1  request accepted this cycle
- fu_ready  out  1  FU start pulse
- fu_op  out  8  op to FU
- fu_rdata1  out  32  src to FU
- fu_rdata2  out  64  {HI,LO} to FU, bypassed
- fu_busy  in  1  FU stalling
- fu_done  in  1  FU cb_we (one-cycle completion)
- fu_wdata  in  32  FU wdata (LO result / mf result)
- fu_extra_wdata  in  32  FU extra_wdata (HI result)
- cb_valid  out  1  completion to commit buffer
- cb_tag  out  TAG_W  completed tag
- rf_we  out  1  GPR write for completed op
- rf_wdata  out  32  GPR write data
- hi_q / lo_q  out  32  architectural HI/LO

## Operation
- States: IDLE, EXEC, DRAIN.
- Accept window is IDLE, or EXEC in the cycle fu_done=1 with flush=0.
- Arbitration in an accept window is fixed priority, slot 0 first. grant1 requires req0_valid=0, which preserves program order. At most one grant per cycle.
- grant is combinational. fu_ready=grant. fu_op/fu_rdata1 are muxed from the granted slot. The controller latches the granted op, tag and rfwe into in-flight registers.
- HI/LO write on fu_done in EXEC:
  - mthi: HI<=fu_extra_wdata.
  - mtlo: LO<=fu_wdata.
  - mult/multu/div/divu: HI<=fu_extra_wdata, LO<=fu_wdata.
  - mfhi/mflo: no write.
- fu_rdata2 bypass: when a grant coincides with a HI/LO-writing fu_done, fu_rdata2 carries the post-write values.
- Completion: in the cycle of fu_done in EXEC, outputs are combinational:
  - cb_valid=1, cb_tag=in-flight tag.
  - rf_we=in-flight rfwe, rf_wdata=fu_wdata.
- Transitions:
  - IDLE→EXEC on grant.
  - EXEC→EXEC on fu_done with a new grant.
  - EXEC→IDLE on fu_done without a grant.
  - EXEC stays while fu_done=0.
- Flush:
  - No grants in the flush cycle.
  - In IDLE, no effect.
  - In EXEC without fu_done, go to DRAIN.
  - fu_done coincident with flush: the result is discarded, with no HI/LO write and no cb_valid. Go to IDLE.
- DRAIN: the FU cannot be annulled. The controller waits for fu_done, discards that result (no HI/LO write, cb_valid=0), then goes to IDLE. A further flush in DRAIN has no extra effect.
- fu_busy is used only as a consistency check: fu_done with fu_busy=1 never occurs.

## Timing
- Reset values:
  - state=IDLE, hi_q=lo_q=0.
  - In-flight op/tag/rfwe = 0.
  - All outputs 0.
- Reset overrides flush and any in-flight op. An FU op abandoned by reset is also reset by the shared resetn.
- Grant cycle N: the FU samples at edge N.
- Completion latency:
  - mf*/mt*: fu_done at N+1.
  - mult/multu: fu_done at N+2.
  - div/divu: fu_done when the divider is ready, about N+34.
- HI/LO update is visible on hi_q/lo_q at N_done+1. The bypass covers a grant at N_done.
- Back-to-back throughput is one op per FU latency, with no bubble.
- Ops complete strictly in grant order, one in flight at a time.

## Test plan
- Reset, then slot0 mthi src=0x12345678 → grant0 at N, cb_valid at N+1, hi_q=0x12345678 at N+2, rf_we=0.
- Both slots valid (slot0 mult 0xFFFFFFFF×2 signed, slot1 mflo): grant0 only at N. At N+2: fu_done, lo update, grant1 with fu_rdata2={0xFFFFFFFF,0xFFFFFFFE} via bypass. At N+3: rf_wdata=0xFFFFFFFE.
- divu 100/7 → cb_valid once after the divider latency, hi_q=2, lo_q=14. No grants in between even with req valid.
- Flush 5 cycles into a div → state DRAIN, no cb_valid, HI/LO unchanged on the div's fu_done, new grant accepted only after.
- flush coincident with mtlo fu_done → no cb_valid, lo_q unchanged, no grant that cycle, IDLE next.
- resetn low mid-mult → all outputs 0 next cycle, hi_q=lo_q=0, state IDLE.
